ahb_sram_ctrl: RTL and testbench

AHB_SRAM_CTRL -- requirements
Module: ahb_sram_ctrl

---
 rtl/ahb_sram_if.sv | 35 +++
 rtl/ahb_sram_ctrl.sv | 85 ++++++++
 tb/tb_ahb_sram_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/ahb_sram_if.sv
// ahb_sram_if: AHB-side and SRAM-pin signals of ahb_sram_ctrl.
// HSIZE/HADDR_LO exist only when AHB_SRAM_SUBWORD_EN is defined.
interface ahb_sram_if;
  logic        HSEL;
  logic [14:0] HADDR;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
`ifdef AHB_SRAM_SUBWORD_EN
  logic [1:0]  HSIZE;
  logic [1:0]  HADDR_LO;
`endif
  logic [18:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;
  modport slave (
`ifdef AHB_SRAM_SUBWORD_EN
    input  HSIZE, HADDR_LO,
`endif
    input  HSEL, HADDR, HWRITE, HWDATA, sram_dq_in,
    output HRDATA, HREADY, sram_addr, sram_dq_out, sram_dq_oe,
    output sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n
  );
  modport master (
`ifdef AHB_SRAM_SUBWORD_EN
    output HSIZE, HADDR_LO,
`endif
    output HSEL, HADDR, HWRITE, HWDATA, sram_dq_in,
    input  HRDATA, HREADY, sram_addr, sram_dq_out, sram_dq_oe,
    input  sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n
  );
endinterface

// File: rtl/ahb_sram_ctrl.sv
// ahb_sram_ctrl: AHB slave accessing a 16-bit async SRAM as two halves per 32-bit word.
// Defining AHB_SRAM_SUBWORD_EN adds halfword/byte transfers touching a single half.
module ahb_sram_ctrl #(
  parameter int WAIT_CYCLES = 1
) (
  input logic       HCLK,
  input logic       HRESET,
  ahb_sram_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LO_SETUP, LO_STROBE, HI_SETUP, HI_STROBE, DONE} state_t;
  state_t      r_state, w_next;
  logic [2:0]  r_cnt;
  logic [14:0] r_addr;
  logic        r_write;
  logic [31:0] r_wdata, r_rdata;
  logic        w_hi, w_setup, w_strobe, w_act, w_last, w_accept;
  logic        w_skip_lo, w_skip_hi, w_single, w_lb_n, w_ub_n;
`ifdef AHB_SRAM_SUBWORD_EN
  logic [1:0]  r_size, r_lo;
  assign w_single  = ~r_size[1];
  assign w_skip_lo = ~bus.HSIZE[1] & bus.HADDR_LO[1];
  assign w_skip_hi = w_single;
  assign w_lb_n    = (r_size == 2'd0) & r_lo[0];
  assign w_ub_n    = (r_size == 2'd0) & ~r_lo[0];
  always_ff @(posedge HCLK)
    if (HRESET) {r_size, r_lo} <= '0;
    else if (w_accept) {r_size, r_lo} <= {bus.HSIZE, bus.HADDR_LO};
`else
  assign w_single  = 1'b0;
  assign w_skip_lo = 1'b0;
  assign w_skip_hi = 1'b0;
  assign w_lb_n    = 1'b0;
  assign w_ub_n    = 1'b0;
`endif
  assign w_accept = (r_state == IDLE) && bus.HSEL;
  assign w_hi     = (r_state == HI_SETUP) || (r_state == HI_STROBE);
  assign w_setup  = (r_state == LO_SETUP) || (r_state == HI_SETUP);
  assign w_strobe = (r_state == LO_STROBE) || (r_state == HI_STROBE);
  assign w_act    = w_setup | w_strobe;
  assign w_last   = r_cnt == 3'd1;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      w_next = bus.HSEL ? (w_skip_lo ? HI_SETUP : LO_SETUP) : IDLE;
      LO_SETUP:  w_next = LO_STROBE;
      LO_STROBE: w_next = w_last ? (w_skip_hi ? DONE : HI_SETUP) : LO_STROBE;
      HI_SETUP:  w_next = HI_STROBE;
      HI_STROBE: w_next = w_last ? DONE : HI_STROBE;
      default:   w_next = IDLE;
    endcase
  end
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next == LO_SETUP || w_next == HI_SETUP) ? 3'(WAIT_CYCLES) :
                 w_strobe ? r_cnt - 3'd1 : r_cnt;
      if (w_accept) begin
        r_addr  <= bus.HADDR;
        r_write <= bus.HWRITE;
        r_wdata <= bus.HWDATA;
      end
      // sub-word reads clear the half they do not touch
      if (w_strobe && w_last && !r_write)
        r_rdata <= w_hi ? {bus.sram_dq_in, w_single ? 16'h0 : r_rdata[15:0]}
                        : {w_single ? 16'h0 : r_rdata[31:16], bus.sram_dq_in};
    end
  end
  assign bus.HRDATA      = r_rdata;
  assign bus.HREADY      = (r_state == DONE) || ((r_state == IDLE) && !bus.HSEL);
  assign bus.sram_addr   = {3'b000, r_addr, w_hi};
  assign bus.sram_dq_out = w_hi ? r_wdata[31:16] : r_wdata[15:0];
  assign bus.sram_dq_oe  = w_strobe & r_write;
  assign bus.sram_ce_n   = ~w_act;
  assign bus.sram_oe_n   = ~(w_strobe & ~r_write);
  assign bus.sram_we_n   = ~(w_strobe & r_write);
  assign bus.sram_lb_n   = ~w_act | w_lb_n;
  assign bus.sram_ub_n   = ~w_act | w_ub_n;
endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// tb_ahb_sram_ctrl: random AHB traffic against a word-level memory model, with a
// behavioural SRAM on the pins and a scoreboard checking each completed transfer.
module tb_ahb_sram_ctrl;
  parameter int W = 1;
  logic HCLK = 1'b0;
  logic HRESET = 1'b1;
  always #5 HCLK = ~HCLK;
  ahb_sram_if bus();
  ahb_sram_ctrl #(.WAIT_CYCLES(W)) dut (.HCLK(HCLK), .HRESET(HRESET), .bus(bus));

  typedef struct {logic wr; logic [31:0] rdata;} exp_t;
  exp_t        sb[$];
  logic [34:0] wlog[$];
  logic [31:0] ref_mem[int];
  logic [15:0] sram[int];
  logic [31:0] last_rd = '0;
  int          n_cmp = 0, n_bad = 0;
  bit          mon_en = 1'b0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] bg(int a);
    return 16'(a * 947) ^ 16'hA5C3;
  endfunction
  function automatic logic [15:0] sram_rd(int a);
    return sram.exists(a) ? sram[a] : bg(a);
  endfunction
  function automatic logic [31:0] ref_rd(int a);
    return ref_mem.exists(a) ? ref_mem[a] : {bg(2 * a + 1), bg(2 * a)};
  endfunction
  function automatic logic [15:0] merge(logic [15:0] o, logic [15:0] d, logic lb_n, logic ub_n);
    return {ub_n ? o[15:8] : d[15:8], lb_n ? o[7:0] : d[7:0]};
  endfunction

  // asynchronous SRAM: writes land while we_n is low, reads present data mid-cycle
  initial forever begin
    @(posedge HCLK);
    if (!bus.sram_ce_n && !bus.sram_we_n)
      sram[int'(bus.sram_addr)] = merge(sram_rd(int'(bus.sram_addr)), bus.sram_dq_out,
                                        bus.sram_lb_n, bus.sram_ub_n);
  end
  initial forever begin
    @(negedge HCLK);
    bus.sram_dq_in = (!bus.sram_ce_n && !bus.sram_oe_n) ? sram_rd(int'(bus.sram_addr)) : 16'h0BAD;
  end

  initial begin : monitor
    int lowcnt, wecnt, oecnt;
    exp_t e;
    lowcnt = 0; wecnt = 0; oecnt = 0;
    forever begin
      @(negedge HCLK);
      if (HRESET || !mon_en) begin
        lowcnt = 0; wecnt = 0; oecnt = 0;
      end else begin
        if (!bus.sram_ce_n) begin
          chk("active_strobes", {bus.sram_dq_oe & ~bus.sram_oe_n, bus.sram_we_n | bus.sram_oe_n,
                                 bus.sram_lb_n, bus.sram_ub_n}, 4'b0100);
          if (!bus.sram_we_n) wlog.push_back({bus.sram_addr, bus.sram_dq_out});
        end else
          chk("inactive_strobes", {bus.sram_oe_n, bus.sram_we_n, bus.sram_lb_n, bus.sram_ub_n,
                                   bus.sram_dq_oe}, 5'b11110);
        wecnt += int'(!bus.sram_we_n);
        oecnt += int'(!bus.sram_oe_n);
        if (!bus.HREADY) lowcnt++;
        else if (lowcnt > 0) begin
          if (sb.size() == 0) chk("unexpected_done", 1, 0);
          else begin
            e = sb.pop_front();
            chk("latency", lowcnt, 3 + 2 * W);
            chk(e.wr ? "hrdata_after_write" : "read_data", bus.HRDATA, e.rdata);
            chk("we_cycles", wecnt, e.wr ? 2 * W : 0);
            chk("oe_cycles", oecnt, e.wr ? 0 : 2 * W);
          end
          lowcnt = 0; wecnt = 0; oecnt = 0;
        end
      end
    end
  end

  // called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again
  task automatic xfer(logic wr, logic [14:0] a, logic [31:0] d);
    exp_t e;
    if (wr) ref_mem[int'(a)] = d;
    else last_rd = ref_rd(int'(a));
    e.wr = wr;
    e.rdata = last_rd;
    sb.push_back(e);
    bus.HSEL = 1'b1; bus.HWRITE = wr; bus.HADDR = a; bus.HWDATA = d;
    @(posedge HCLK); #1;
    for (int i = 0; ; i++) begin
      if (i >= 40) begin
        chk("done_timeout", 0, 1);
        break;
      end
      bus.HSEL = 1'($urandom); bus.HWRITE = 1'($urandom);
      bus.HADDR = 15'($urandom); bus.HWDATA = $urandom;
      @(posedge HCLK); #1;
      if (bus.HREADY) break;
    end
    bus.HSEL = 1'b0;
    @(posedge HCLK); #1;
    repeat ($urandom_range(0, 2)) begin
      @(posedge HCLK); #1;
    end
  endtask

  task automatic check_reset_state(string tag);
    chk({tag, "_hready"}, bus.HREADY, 1);
    chk({tag, "_hrdata"}, bus.HRDATA, 0);
    chk({tag, "_strobes"}, {bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_lb_n,
                            bus.sram_ub_n, bus.sram_dq_oe}, 6'b111110);
    chk({tag, "_sram_addr"}, bus.sram_addr, 0);
    chk({tag, "_dq_out"}, bus.sram_dq_out, 0);
  endtask

  initial begin
    int n;
    bus.HSEL = 1'b0; bus.HWRITE = 1'b0; bus.HADDR = '0; bus.HWDATA = '0;
`ifdef AHB_SRAM_SUBWORD_EN
    bus.HSIZE = 2'd2; bus.HADDR_LO = 2'd0;
`endif
    sram[10] = 16'h1234;
    sram[11] = 16'h5678;
    ref_mem[5] = 32'h5678_1234;
    repeat (3) @(posedge HCLK);
    #1 HRESET = 1'b0;
    @(negedge HCLK);
    check_reset_state("reset");
    @(posedge HCLK); #1;
    mon_en = 1'b1;
    xfer(1'b0, 15'h0005, '0);
    wlog.delete();
    xfer(1'b1, 15'h0005, 32'hDEADBEEF);
    chk("write_seq_len", wlog.size(), 2 * W);
    for (int i = 0; i < wlog.size() && i < 2 * W; i++)
      chk("write_seq", wlog[i], i < W ? {19'h0000A, 16'hBEEF} : {19'h0000B, 16'hDEAD});
    xfer(1'b0, 15'h0005, '0);
    xfer(1'b1, 15'h7FFF, $urandom);
    xfer(1'b0, 15'h7FFF, '0);
    xfer(1'b1, 15'h0000, $urandom);
    xfer(1'b0, 15'h0000, '0);
    repeat (200) xfer(1'($urandom), 15'($urandom_range(0, 15)), $urandom);
    chk("scoreboard_drained", sb.size(), 0);
    mon_en = 1'b0;
`ifdef AHB_SRAM_SUBWORD_EN
    bus.HSEL = 1'b1; bus.HWRITE = 1'b1; bus.HADDR = 15'h0005; bus.HWDATA = 32'hAB00_0000;
    bus.HSIZE = 2'd0; bus.HADDR_LO = 2'b11;
    @(posedge HCLK); #1;
    bus.HSEL = 1'b0;
    n = 1;
    while (!bus.HREADY && n < 20) begin
      if (!bus.sram_we_n)
        chk("byte_write_pins", {bus.sram_addr, bus.sram_dq_out, bus.sram_lb_n, bus.sram_ub_n},
            {19'h0000B, 16'hAB00, 2'b10});
      @(posedge HCLK); #1;
      n++;
    end
    chk("byte_write_latency", n, 2 + W);
    bus.HSIZE = 2'd2; bus.HADDR_LO = 2'd0;
    @(posedge HCLK); #1;
`endif
    bus.HSEL = 1'b1; bus.HWRITE = 1'b1; bus.HADDR = 15'h0003; bus.HWDATA = $urandom;
    @(posedge HCLK); #1;
    bus.HSEL = 1'b0;
    n = 0;
    while (!(!bus.sram_we_n && bus.sram_addr[0]) && n < 20) begin
      @(posedge HCLK); #1;
      n++;
    end
    chk("reach_hi_strobe", n < 20, 1);
    HRESET = 1'b1;
    repeat (2) @(posedge HCLK);
    #1 HRESET = 1'b0;
    @(negedge HCLK);
    check_reset_state("midxfer_reset");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
